// File: rtl/tft_fb_arbiter_if.sv
// rtl/tft_fb_arbiter_if.sv - decoder write handshake and shared image RAM bus
// slave: arbiter side; master: decoder/RAM side.
interface tft_fb_arbiter_if;
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        ram_en;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, ram_rdata,
        output wr_ack, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_ack, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/tft_fb_arbiter.sv
// rtl/tft_fb_arbiter.sv - display-read-priority arbiter for the 128x128 RGB565 image RAM
// Optional macro FB_ARB_BORDER_EN: draw a BORDER_COLOR ring just outside the image window.
module tft_fb_arbiter #(
    parameter int          H_VALID      = 800,
    parameter int          V_VALID      = 480,
    parameter int          WIDTH        = 128,
    parameter int          HEIGHT       = 128,
    parameter int          PIC_SIZE     = 16384,
    parameter logic [15:0] BORDER_COLOR = 16'hFFFF
) (
    input  logic                tft_sclk_33m,
    input  logic                srst,
    input  logic [10:0]         pix_x,
    input  logic [10:0]         pix_y,
    input  logic                clr_image,
    tft_fb_arbiter_if.slave     bus,
    output logic [15:0]         pix_rgb,
    output logic                pix_valid,
    output logic                image_ready
);
    localparam int X0 = (H_VALID - WIDTH) / 2;
    localparam int Y0 = (V_VALID - HEIGHT) / 2;

    typedef enum logic {LOAD, SHOW} state_t;

    state_t      state, state_nxt;
    logic [14:0] wr_cnt, cnt_nxt;
    logic        in_win, on_ring;
    logic        rd_go, wr_go;
    logic [13:0] rd_addr;
    logic        rd_q, ring_q, valid_q;
    logic [15:0] rgb_q;

    assign in_win = (pix_x >= 11'(X0)) && (pix_x < 11'(X0 + WIDTH)) &&
                    (pix_y >= 11'(Y0)) && (pix_y < 11'(Y0 + HEIGHT));

    assign rd_addr = 14'(pix_y - 11'(Y0)) * 14'(WIDTH) + 14'(pix_x - 11'(X0));

`ifdef FB_ARB_BORDER_EN
    assign on_ring = (((pix_x == 11'(X0 - 1)) || (pix_x == 11'(X0 + WIDTH))) &&
                      (pix_y >= 11'(Y0 - 1)) && (pix_y <= 11'(Y0 + HEIGHT))) ||
                     (((pix_y == 11'(Y0 - 1)) || (pix_y == 11'(Y0 + HEIGHT))) &&
                      (pix_x >= 11'(X0 - 1)) && (pix_x <= 11'(X0 + WIDTH)));
`else
    assign on_ring = 1'b0;
`endif

    always_ff @(posedge tft_sclk_33m) begin
        if (!srst) begin
            state  <= LOAD;
            wr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= cnt_nxt;
        end
    end

    // Display reads win every cycle they occur; writes only fill the remaining slots.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = wr_cnt;
        rd_go         = 1'b0;
        wr_go         = 1'b0;
        bus.wr_ack    = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        image_ready   = 1'b0;

        if (in_win)
            rd_go = 1'b1;
        else if (state == LOAD && bus.wr_req && !clr_image)
            wr_go = 1'b1;

        if (clr_image) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else if (wr_go) begin
            cnt_nxt = wr_cnt + 15'd1;
            if (cnt_nxt == 15'(PIC_SIZE))
                state_nxt = SHOW;
        end

        if (srst) begin
            image_ready = (state == SHOW);
            bus.wr_ack  = wr_go;
            bus.ram_en  = rd_go || wr_go;
            bus.ram_we  = wr_go;
            if (rd_go) begin
                bus.ram_addr = rd_addr;
            end else if (wr_go) begin
                bus.ram_addr  = bus.wr_addr;
                bus.ram_wdata = bus.wr_data;
            end
        end
    end

    // Two-stage read pipeline: issue, then capture the RAM's registered output.
    always_ff @(posedge tft_sclk_33m) begin
        if (!srst) begin
            rd_q    <= 1'b0;
            ring_q  <= 1'b0;
            valid_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            rd_q    <= rd_go;
            ring_q  <= on_ring;
            valid_q <= rd_q || ring_q;
            if (rd_q)
                rgb_q <= bus.ram_rdata;
            else if (ring_q)
                rgb_q <= BORDER_COLOR;
        end
    end

    assign pix_rgb   = srst ? rgb_q : 16'd0;
    assign pix_valid = srst && valid_q;
endmodule

// File: doc/tft_fb_arbiter.md
Name: tft_fb_arbiter

Overview:
Shares one single-port 128x128 RGB565 image RAM between two requesters: the ETC2 decoder write stream and the TFT pixel read path.
- Display reads inside the centred image window always have priority.
- Decoder writes use a req/ack handshake and are issued only in cycles with no display read.
- Tracks image load completion and presents `image_ready` and pixel data to the TFT pixel mux, beside the colour-bar pattern generator.

Parameters:
- H_VALID, 800, active pixels per line
- V_VALID, 480, active lines per frame
- WIDTH, 128, image width in pixels
- HEIGHT, 128, image height in lines
- PIC_SIZE, 16384, WIDTH*HEIGHT; write count that completes an image
- BORDER_COLOR, 16'hFFFF, border colour (optional feature only)

Ports:
- tft_sclk_33m  in  1  clock
- srst  in  1  synchronous active-low reset
- pix_x  in  11  current TFT column
- pix_y  in  11  current TFT row
- clr_image  in  1  one-cycle pulse: discard image, restart loading
- wr_req  in  1  decoder write request; held until wr_ack
- wr_addr  in  14  pixel index, y*WIDTH+x
- wr_data  in  16  RGB565 pixel
- wr_ack  out  1  one-cycle pulse: write issued this cycle
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  14  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid one cycle after the read address
- pix_rgb  out  16  image pixel for the TFT mux
- pix_valid  out  1  pix_rgb is an image pixel
- image_ready  out  1  all PIC_SIZE writes accepted

Behaviour:
- Reset is srst, synchronous, active-low; clock is tft_sclk_33m.
- While srst=0, all outputs are 0: wr_ack, ram_en, ram_we, ram_addr, ram_wdata, pix_rgb, pix_valid, image_ready. State=LOAD, wr_cnt=0.
- Window origin: X0=(H_VALID-WIDTH)/2=336, Y0=(V_VALID-HEIGHT)/2=176.
- in_win = (X0<=pix_x<X0+WIDTH) && (Y0<=pix_y<Y0+HEIGHT). It is combinational from pix_x/pix_y.
- Read address = (pix_y-Y0)*WIDTH + (pix_x-X0), truncated to 14 bits. The multiply is a shift by 7.
- The ram_* outputs are combinational from the current-cycle decision and are forced to 0 while srst=0.
- Per-cycle arbitration, priority high to low:
  - in_win: read; ram_en=1, ram_we=0, ram_addr=read address; wr_ack=0.
  - else if state=LOAD, wr_req=1, clr_image=0: write; ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1.
  - else: idle; ram_en=0, ram_we=0, wr_ack=0.
- Read pipeline:
  - A read issued in cycle N registers a valid flag at N+1.
  - At N+2, pix_rgb is ram_rdata captured at N+1 and pix_valid=1.
  - Total latency from pix_x/pix_y to pix_rgb is 2 cycles.
  - With no read issued, pix_valid=0 two cycles later and pix_rgb holds its previous value.
- State machine LOAD/SHOW:
  - LOAD: each wr_ack increments wr_cnt (15 bits). Duplicate addresses are still counted.
  - The ack that makes wr_cnt=PIC_SIZE moves the block to SHOW next cycle; image_ready=1 from that cycle.
  - SHOW: wr_req is ignored (wr_ack=0, no RAM write). Reads continue. wr_cnt holds.
  - clr_image=1 in either state: next cycle state=LOAD, wr_cnt=0, image_ready=0.
- Reads during LOAD are legal and show a partially loaded image.
- Boundary cases:
  - clr_image in the same cycle as a pending write: clr wins, no ack, no RAM write.
  - Write pending while in_win: stalls until in_win=0. There is no starvation limit; blanking and out-of-window pixels guarantee write slots.
  - Window edges: pix_x=335 gives no read; 336 gives read address row*128+0; 463 gives row*128+127; 464 gives no read. The same edge rule applies to pix_y=175/176/303/304.
  - Reset mid-write: wr_ack=0 that cycle and the decoder retries after reset.

Optional Feature:
- Macro: FB_ARB_BORDER_EN.
- Defined:
  - A 1-pixel ring just outside the window (x in {335,464} with y in 175..304, or y in {175,304} with x in 335..464) outputs BORDER_COLOR.
  - pix_valid=1 for these pixels with the same 2-cycle latency.
  - No RAM read is issued for the ring, so write slots are unaffected.
- Not defined: ring pixels behave as normal out-of-window pixels (pix_valid=0).

Test Plan:
1. Reset: hold srst=0 for 5 cycles with wr_req=1 and pix in window -> all outputs 0, no ram_en.
2. Load: pix outside window, wr_req held, 16384 sequential writes -> one wr_ack per cycle; image_ready=1 on the cycle after the 16384th ack; the next wr_req is not acked.
3. Priority: wr_req=1 while pix_x steps 334..338 at pix_y=176 -> wr_ack only at x=334,335; reads at ram_addr 0,1,2 for x=336..338; the write resumes when x leaves the window.
4. Read latency: preload addr 129 with 16'h1234, drive pix_x=337, pix_y=177 -> ram_addr=129 in cycle N; pix_rgb=16'h1234 and pix_valid=1 at N+2.
5. clr_image in the same cycle as a pending write in SHOW, and again in LOAD at wr_cnt=100 -> no ack; next cycle image_ready=0, wr_cnt=0.
6. FB_ARB_BORDER_EN: pix_x=335, pix_y=200 -> pix_rgb=16'hFFFF, pix_valid=1 after 2 cycles, ram_en=0. Without the macro -> pix_valid=0.
